reco_dot_stage: RTL and testbench
=================================

// Module: reco_dot_stage
// PURPOSE
//  Upstream neighbour of the recommender gradient stage in the Axiline training pipe.
//  Computes the signed fixed-point dot product of a feature vector x and a weight vector w.
//  Consumes LANES element pairs per accepted beat, VEC_LEN elements in total.
//  Presents the result on data_out with a one-cycle valid_out pulse; this feeds the
//  gradient stage's data_in/valid directly.
// PARAMETERS
//  bitwidth       32  accumulator and data_out width (signed, two's complement)
//  inputBitwidth  16  width of each x/w element (signed fixed point)
//  LANES          4   element pairs consumed per beat; VEC_LEN % LANES == 0 required
//  VEC_LEN        64  vector length in elements; beats per vector = VEC_LEN/LANES
//  FRAC           8   fractional bits; each product is arithmetically shifted right by FRAC
// PORTS
//  clk        in   1                      clock, all logic on posedge
//  rst        in   1                      synchronous, active-high reset
//  start      in   1                      begin a new vector (honoured in IDLE only)
//  in_valid   in   1                      x_in/w_in beat valid
//  in_ready   out  1                      stage accepts a beat (high only in ACC)
//  x_in       in   LANES*inputBitwidth    lane k at [k*inputBitwidth +: inputBitwidth]
//  w_in       in   LANES*inputBitwidth    same packing as x_in
//  data_out   out  bitwidth               dot-product result; held until the next result
//  valid_out  out  1                      one-cycle pulse, data_out is new
//  busy       out  1                      state != IDLE
//  ovf        out  1                      sticky saturation flag for the current vector
// BEHAVIOUR
//  - Reset (sync, rst high at posedge):
//    - state=IDLE; acc, beat count, data_out, valid_out, ovf all 0.
//    - Reset wins over every other input, including mid-vector; the partial sum is discarded.
//  - FSM states: IDLE, ACC, DONE.
//    - IDLE: start -> ACC, acc<=0, ovf<=0, count<=VEC_LEN/LANES. in_valid is ignored.
//    - ACC: beat accepted when in_valid && in_ready; acc<=acc+lanesum; count decrements.
//      On the last beat: data_out<=final acc, valid_out<=1, state->DONE.
//      Cycles with in_valid=0 are stalls; there is no timeout.
//    - DONE: lasts 1 cycle, in_ready=0; valid_out<=0, state->IDLE.
//  - start while in ACC or DONE is ignored; it is not queued.
//  - start and in_valid in the same IDLE cycle: only start takes effect; the beat is not accepted.
//  - Latency: valid_out is high in the cycle after the edge that accepts the last beat.
//    Minimum vector period is VEC_LEN/LANES + 2 cycles (start, beats, DONE).
//  - in_ready is a combinational decode of state, with no dependence on in_valid.
//  - Arithmetic:
//    - Product: p_k = $signed(x_k)*$signed(w_k), 2*inputBitwidth bits, then p_k >>> FRAC.
//    - lanesum: sign-extended sum of all p_k, width 2*inputBitwidth+$clog2(LANES).
//    - lanesum is sign-extended (or truncated) to bitwidth before accumulating.
//  - busy = (state != IDLE). valid_out is never high in the IDLE-after-reset cycle.
// CONFIGURATION
//  RECO_DOT_SAT_EN defined:
//    - Each accumulate clamps to [-2^(bitwidth-1), 2^(bitwidth-1)-1].
//    - Any clamp sets ovf, which stays set until the next accepted start or rst.
//  RECO_DOT_SAT_EN undefined:
//    - Accumulate wraps modulo 2^bitwidth.
//    - ovf is tied to 0; no clamp logic is built.
// TESTING  (bench: LANES=4, VEC_LEN=8, FRAC=0 unless noted)
//  1. start; beats x={1,1,1,1}/w={1,2,3,4}, then x={1,1,1,1}/w={5,6,7,8}
//     -> valid_out 1 cycle after the 2nd beat, data_out=36; busy low 2 cycles after the 2nd beat.
//  2. x all -1, w all 3, 2 beats -> data_out=-24 (0xFFFFFFE8), ovf=0.
//  3. Same as (1) with 3 idle cycles between beats -> data_out=36, in_ready high throughout ACC.
//  4. rst after the 1st beat -> next cycle: busy=0, data_out=0, valid_out=0.
//     A new start plus the (1) stimulus -> 36.
//  5. in_valid in IDLE with no start -> no acceptance; start during ACC -> ignored, result still 36.
//  6. bitwidth=20, x=w=32767 in all lanes, 2 beats:
//     - with RECO_DOT_SAT_EN: data_out=0x7FFFF, ovf=1.
//     - without: data_out=0x80008, ovf=0.

Source files
------------

// File: rtl/reco_dot_stage.sv
// rtl/reco_dot_stage.sv - signed fixed-point dot product of x and w, LANES pairs per beat
// Optional clamp-on-accumulate with sticky ovf: define RECO_DOT_SAT_EN.
module reco_dot_stage #(
  parameter int bitwidth      = 32,
  parameter int inputBitwidth = 16,
  parameter int LANES         = 4,
  parameter int VEC_LEN       = 64,
  parameter int FRAC          = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*inputBitwidth-1:0]   x_in,
  input  logic [LANES*inputBitwidth-1:0]   w_in,
  output logic [bitwidth-1:0]              data_out,
  output logic                             valid_out,
  output logic                             busy,
  output logic                             ovf
);
  localparam int BEATS = VEC_LEN / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int PW    = 2 * inputBitwidth;
  localparam int LSW   = PW + $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                       state, state_next;
  logic signed [bitwidth-1:0]   acc, acc_sum;
  logic        [CW-1:0]         count;
  logic signed [LSW-1:0]        lanesum;
  logic signed [inputBitwidth-1:0] xk, wk;
  logic signed [PW-1:0]         prod;
  logic                         accept, last_beat;

  assign in_ready  = (state == ACC);
  assign busy      = (state != IDLE);
  assign accept    = in_ready && in_valid;
  assign last_beat = (count == CW'(1));

  // Each product is rescaled before the lane sum so every lane carries the same fixed-point format.
  always_comb begin
    lanesum = '0;
    xk      = '0;
    wk      = '0;
    prod    = '0;
    for (int k = 0; k < LANES; k++) begin
      xk      = x_in[k*inputBitwidth +: inputBitwidth];
      wk      = w_in[k*inputBitwidth +: inputBitwidth];
      prod    = PW'(xk) * PW'(wk);
      lanesum = lanesum + LSW'(prod >>> FRAC);
    end
  end

`ifdef RECO_DOT_SAT_EN
  // Clamp decision uses the full-precision sum so a lanesum wider than bitwidth saturates correctly.
  localparam int SW = ((bitwidth > LSW) ? bitwidth : LSW) + 1;
  localparam logic signed [SW-1:0] SMAX = {{(SW-bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  logic signed [SW-1:0] wide_sum;
  logic                 clamp;

  always_comb begin
    wide_sum = SW'(acc) + SW'(lanesum);
    clamp    = 1'b0;
    acc_sum  = wide_sum[bitwidth-1:0];
    if (wide_sum > SMAX) begin
      acc_sum = SMAX[bitwidth-1:0];
      clamp   = 1'b1;
    end else if (wide_sum < SMIN) begin
      acc_sum = SMIN[bitwidth-1:0];
      clamp   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf <= 1'b0;
    end else if (accept && clamp) begin
      ovf <= 1'b1;
    end
  end
`else
  always_comb begin
    acc_sum = acc + bitwidth'(lanesum);
  end

  assign ovf = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACC;
      ACC:     if (accept && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            count <= CW'(BEATS);
          end
        end
        ACC: begin
          if (accept) begin
            acc   <= acc_sum;
            count <= count - CW'(1);
            if (last_beat) begin
              data_out  <= acc_sum;
              valid_out <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reco_dot_stage.sv
// tb/tb_reco_dot_stage.sv - scoreboard bench for reco_dot_stage at bitwidth 32 and 20
// Both instances share stimulus; RECO_DOT_SAT_EN selects the reference rule.
module tb_reco_dot_stage;
  localparam int IW    = 16;
  localparam int LANES = 4;
  localparam int VLEN  = 8;
  localparam int FRAC  = 0;
  localparam int BEATS = VLEN / LANES;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst, start, in_valid;
  logic [LANES*IW-1:0]   x_in, w_in;
  logic                  in_ready_a, valid_out_a, busy_a, ovf_a;
  logic [31:0]           data_out_a;
  logic                  in_ready_b, valid_out_b, busy_b, ovf_b;
  logic [19:0]           data_out_b;

  int   checks   = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [IW-1:0] vx[VLEN];
  logic [IW-1:0] vw[VLEN];

  always #5 clk = ~clk;

  reco_dot_stage #(.bitwidth(32), .inputBitwidth(IW), .LANES(LANES), .VEC_LEN(VLEN), .FRAC(FRAC)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .x_in(x_in), .w_in(w_in), .data_out(data_out_a), .valid_out(valid_out_a),
    .busy(busy_a), .ovf(ovf_a));

  reco_dot_stage #(.bitwidth(20), .inputBitwidth(IW), .LANES(LANES), .VEC_LEN(VLEN), .FRAC(FRAC)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .x_in(x_in), .w_in(w_in), .data_out(data_out_b), .valid_out(valid_out_b),
    .busy(busy_b), .ovf(ovf_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Exact integer arithmetic over the vector, then wrap or clamp to bw bits after every beat.
  function automatic exp_t model(input int bw);
    exp_t   e;
    longint acc, ls, maxv, minv, m, mask;
    acc  = 0;
    e.o  = 1'b0;
    maxv = (longint'(1) <<< (bw - 1)) - 1;
    minv = -maxv - 1;
    m    = longint'(1) << bw;
    mask = m - 1;
    for (int b = 0; b < BEATS; b++) begin
      ls = 0;
      for (int k = 0; k < LANES; k++)
        ls += (longint'($signed(vx[b*LANES+k])) * longint'($signed(vw[b*LANES+k]))) >>> FRAC;
      acc += ls;
`ifdef RECO_DOT_SAT_EN
      if (acc > maxv) begin acc = maxv; e.o = 1'b1; end
      else if (acc < minv) begin acc = minv; e.o = 1'b1; end
`else
      acc = acc % m;
      if (acc > maxv) acc -= m;
      else if (acc < minv) acc += m;
`endif
    end
    acc = acc & mask;
    e.d = acc[31:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && valid_out_a) begin
      if (qa.size() == 0) chk("a_unexpected_valid", {31'b0, valid_out_a}, 32'd0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_data", data_out_a, e.d);
        chk("a_ovf", {31'b0, ovf_a}, {31'b0, e.o});
      end
    end
    if (!rst && valid_out_b) begin
      if (qb.size() == 0) chk("b_unexpected_valid", {31'b0, valid_out_b}, 32'd0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_data", {12'b0, data_out_b}, e.d);
        chk("b_ovf", {31'b0, ovf_b}, {31'b0, e.o});
      end
    end
  end

  task automatic load_beat(input int b);
    for (int k = 0; k < LANES; k++) begin
      x_in[k*IW +: IW] = vx[b*LANES+k];
      w_in[k*IW +: IW] = vw[b*LANES+k];
    end
  endtask

  task automatic do_vector(input int gap, input bit poke);
    exp_t ea, eb;
    ea = model(32);
    eb = model(20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy_a}, 32'd1);
    for (int b = 0; b < BEATS; b++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        start    = poke;
        chk("in_ready_stall", {31'b0, in_ready_a}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      load_beat(b);
      chk("in_ready_beat", {31'b0, in_ready_a}, 32'd1);
      if (b == BEATS - 1) begin
        qa.push_back(ea);
        qb.push_back(eb);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("valid_latency", {31'b0, valid_out_a}, 32'd1);
    chk("done_busy", {31'b0, busy_a}, 32'd1);
    chk("done_in_ready", {31'b0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    chk("valid_pulse_end", {31'b0, valid_out_a}, 32'd0);
    chk("busy_back_idle", {31'b0, busy_a}, 32'd0);
  endtask

  task automatic set_t1();
    for (int i = 0; i < VLEN; i++) begin
      vx[i] = 16'd1;
      vw[i] = 16'(i + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; x_in = '0; w_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_data_a", data_out_a, 32'd0);
    chk("rst_data_b", {12'b0, data_out_b}, 32'd0);
    chk("rst_valid", {31'b0, valid_out_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready_a}, 32'd0);
    chk("rst_ovf", {31'b0, ovf_b}, 32'd0);
    @(posedge clk); #1;
    chk("idle_after_rst_valid", {31'b0, valid_out_a}, 32'd0);

    set_t1();
    do_vector(0, 1'b0);
    chk("t1_result", data_out_a, 32'd36);

    for (int i = 0; i < VLEN; i++) begin vx[i] = 16'hFFFF; vw[i] = 16'd3; end
    do_vector(0, 1'b0);
    chk("t2_result", data_out_a, 32'hFFFFFFE8);
    chk("t2_ovf", {31'b0, ovf_a}, 32'd0);

    set_t1();
    do_vector(3, 1'b0);
    chk("t3_result", data_out_a, 32'd36);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; load_beat(0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_busy", {31'b0, busy_a}, 32'd0);
    chk("t4_data_a", data_out_a, 32'd0);
    chk("t4_data_b", {12'b0, data_out_b}, 32'd0);
    chk("t4_valid", {31'b0, valid_out_a}, 32'd0);
    do_vector(0, 1'b0);
    chk("t4_result", data_out_a, 32'd36);

    in_valid = 1'b1; load_beat(1);
    repeat (2) begin
      chk("t5_idle_in_ready", {31'b0, in_ready_a}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t5_still_idle", {31'b0, busy_a}, 32'd0);
    do_vector(1, 1'b1);
    chk("t5_result", data_out_a, 32'd36);

    for (int i = 0; i < VLEN; i++) begin vx[i] = 16'd32767; vw[i] = 16'd32767; end
    do_vector(0, 1'b0);
`ifdef RECO_DOT_SAT_EN
    chk("t6_data_b", {12'b0, data_out_b}, 32'h7FFFF);
    chk("t6_ovf_b", {31'b0, ovf_b}, 32'd1);
`else
    chk("t6_data_b", {12'b0, data_out_b}, 32'h80008);
    chk("t6_ovf_b", {31'b0, ovf_b}, 32'd0);
`endif

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < VLEN; i++) begin
        vx[i] = 16'($urandom);
        vw[i] = 16'($urandom);
      end
      do_vector(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
